// File: rtl/butterfly_xbar_in_pipe_if.sv
// Handshake and data bundle between the SRAM read path and the butterfly input crossbar.
interface butterfly_xbar_in_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int LANES    = 4,
  parameter int STRIDE_W = 10
);
  logic [STRIDE_W-1:0]     i_STRIDE;
  logic [LANES*DATA_W-1:0] i_READ_OUTPUT1;
  logic [LANES*DATA_W-1:0] i_READ_OUTPUT2;
  logic                    i_VALID;
  logic                    o_READY;
  logic [LANES*DATA_W-1:0] o_BUTTERFLY_TOP;
  logic [LANES*DATA_W-1:0] o_BUTTERFLY_BOTTOM;
  logic                    o_VALID;
  logic                    i_READY;

  modport master (
    output i_STRIDE, i_READ_OUTPUT1, i_READ_OUTPUT2, i_VALID, i_READY,
    input  o_READY, o_BUTTERFLY_TOP, o_BUTTERFLY_BOTTOM, o_VALID
  );

  modport slave (
    input  i_STRIDE, i_READ_OUTPUT1, i_READ_OUTPUT2, i_VALID, i_READY,
    output o_READY, o_BUTTERFLY_TOP, o_BUTTERFLY_BOTTOM, o_VALID
  );
endinterface

// File: rtl/butterfly_xbar_in_pipe.sv
// Routes two read beats into LANES butterfly operand pairs for a power-of-two stride,
// behind an output register plus one skid register, with an output beat counter.
module butterfly_xbar_in_pipe #(
  parameter int DATA_W   = 32,
  parameter int LANES    = 4,
  parameter int STRIDE_W = 10,
  parameter int CNT_W    = 8
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic                          i_CLEAR,
  butterfly_xbar_in_pipe_if.slave       bus,
  output logic [CNT_W-1:0]              o_BEAT_CNT
);
  localparam int LOG_L = $clog2(LANES);
  localparam int BUS_W = LANES * DATA_W;

  // log2 of the effective stride: msb of the stride, zero maps to 1, clamped to LANES
  function automatic int eff_stride_log(input logic [STRIDE_W-1:0] st);
    int p;
    p = 0;
    for (int i = 0; i < STRIDE_W; i++) begin
      p = st[i] ? i : p;
    end
    return (p > LOG_L) ? LOG_L : p;
  endfunction

  logic [DATA_W-1:0] w_s [2*LANES];
  logic [BUS_W-1:0]  top_s;
  logic [BUS_W-1:0]  bot_s;
  int                k_s;
  logic              accept_s;
  logic              drain_s;

  logic              or_valid_r;
  logic [BUS_W-1:0]  or_top_r;
  logic [BUS_W-1:0]  or_bot_r;
  logic              sk_valid_r;
  logic [BUS_W-1:0]  sk_top_r;
  logic [BUS_W-1:0]  sk_bot_r;
  logic              ready_r;
  logic [CNT_W-1:0]  cnt_r;

  // Unpack both read beats into one concatenated word array
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      w_s[j]         = bus.i_READ_OUTPUT1[j*DATA_W +: DATA_W];
      w_s[j + LANES] = bus.i_READ_OUTPUT2[j*DATA_W +: DATA_W];
    end
  end

  // Crossbar: every stride choice is built with constant indices, then selected
  always_comb begin
    k_s   = eff_stride_log(bus.i_STRIDE);
    top_s = '0;
    bot_s = '0;
    for (int k = 0; k <= LOG_L; k++) begin
      for (int b = 0; b < LANES; b++) begin
        top_s[b*DATA_W +: DATA_W] = (k_s == k)
          ? w_s[((b >> k) << (k + 1)) + (b % (1 << k))]
          : top_s[b*DATA_W +: DATA_W];
        bot_s[b*DATA_W +: DATA_W] = (k_s == k)
          ? w_s[((b >> k) << (k + 1)) + (b % (1 << k)) + (1 << k)]
          : bot_s[b*DATA_W +: DATA_W];
      end
    end
  end

  assign accept_s = bus.i_VALID & ready_r;
  assign drain_s  = or_valid_r & bus.i_READY;

  // Output and skid registers; ready tracks skid-empty, so accept never meets a full skid
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      or_valid_r <= 1'b0;
      or_top_r   <= '0;
      or_bot_r   <= '0;
      sk_valid_r <= 1'b0;
      sk_top_r   <= '0;
      sk_bot_r   <= '0;
      ready_r    <= 1'b1;
    end else if (drain_s && sk_valid_r) begin
      or_top_r   <= sk_top_r;
      or_bot_r   <= sk_bot_r;
      or_valid_r <= 1'b1;
      sk_valid_r <= 1'b0;
      ready_r    <= 1'b1;
    end else if (accept_s && (!or_valid_r || drain_s)) begin
      or_top_r   <= top_s;
      or_bot_r   <= bot_s;
      or_valid_r <= 1'b1;
    end else if (accept_s) begin
      sk_top_r   <= top_s;
      sk_bot_r   <= bot_s;
      sk_valid_r <= 1'b1;
      ready_r    <= 1'b0;
    end else if (drain_s) begin
      or_valid_r <= 1'b0;
    end
  end

  // Output beat counter; clear wins over a simultaneous transfer
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      cnt_r <= '0;
    end else if (i_CLEAR) begin
      cnt_r <= '0;
    end else if (drain_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.o_VALID            = or_valid_r;
  assign bus.o_BUTTERFLY_TOP    = or_top_r;
  assign bus.o_BUTTERFLY_BOTTOM = or_bot_r;
  assign bus.o_READY            = ready_r;
  assign o_BEAT_CNT             = cnt_r;
endmodule

// File: tb/tb_butterfly_xbar_in_pipe.sv
// Directed bench for butterfly_xbar_in_pipe with hand-computed routing results (LANES=4).
module tb_butterfly_xbar_in_pipe;
  logic       clk;
  logic       rst;
  logic       clear;
  logic [7:0] cnt;
  int         total;
  int         bad;

  localparam logic [127:0] S1_TOP = 128'h00000106_00000104_00000102_00000100;
  localparam logic [127:0] S1_BOT = 128'h00000107_00000105_00000103_00000101;
  localparam logic [127:0] S2_TOP = 128'h00000105_00000104_00000101_00000100;
  localparam logic [127:0] S2_BOT = 128'h00000107_00000106_00000103_00000102;
  localparam logic [127:0] S4_TOP = 128'h00000103_00000102_00000101_00000100;
  localparam logic [127:0] S4_BOT = 128'h00000107_00000106_00000105_00000104;
  localparam logic [127:0] B_TOP  = 128'h00000203_00000202_00000201_00000200;
  localparam logic [127:0] C_TOP  = 128'h00000303_00000302_00000301_00000300;

  butterfly_xbar_in_pipe_if #(.DATA_W(32), .LANES(4), .STRIDE_W(10)) bus ();

  butterfly_xbar_in_pipe #(.DATA_W(32), .LANES(4), .STRIDE_W(10), .CNT_W(8)) dut (
    .i_CLK      (clk),
    .i_RST      (rst),
    .i_CLEAR    (clear),
    .bus        (bus.slave),
    .o_BEAT_CNT (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] base);
    for (int j = 0; j < 4; j++) begin
      bus.i_READ_OUTPUT1[j*32 +: 32] = base + 32'(j);
      bus.i_READ_OUTPUT2[j*32 +: 32] = base + 32'(j + 4);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear = 1'b0;
    bus.i_VALID  = 1'b0;
    bus.i_READY  = 1'b1;
    bus.i_STRIDE = 10'd1;
    set_words(32'h100);
    #12;
    chk_eq("rst_valid", bus.o_VALID, 128'd0);
    chk_eq("rst_ready", bus.o_READY, 128'd1);
    chk_eq("rst_top", bus.o_BUTTERFLY_TOP, 128'd0);
    chk_eq("rst_bot", bus.o_BUTTERFLY_BOTTOM, 128'd0);
    chk_eq("rst_cnt", cnt, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // stride 1 single beat
    bus.i_VALID = 1'b1;
    bus.i_STRIDE = 10'd1;
    tick();
    bus.i_VALID = 1'b0;
    chk_eq("s1_valid", bus.o_VALID, 128'd1);
    chk_eq("s1_top", bus.o_BUTTERFLY_TOP, S1_TOP);
    chk_eq("s1_bot", bus.o_BUTTERFLY_BOTTOM, S1_BOT);
    tick();
    chk_eq("s1_drained", bus.o_VALID, 128'd0);
    chk_eq("s1_cnt", cnt, 128'd1);

    // stride 2 then 3
    bus.i_VALID = 1'b1;
    bus.i_STRIDE = 10'd2;
    tick();
    chk_eq("s2_top", bus.o_BUTTERFLY_TOP, S2_TOP);
    chk_eq("s2_bot", bus.o_BUTTERFLY_BOTTOM, S2_BOT);
    bus.i_STRIDE = 10'd3;
    tick();
    bus.i_VALID = 1'b0;
    chk_eq("s3_valid", bus.o_VALID, 128'd1);
    chk_eq("s3_top", bus.o_BUTTERFLY_TOP, S2_TOP);
    chk_eq("s3_bot", bus.o_BUTTERFLY_BOTTOM, S2_BOT);
    tick();
    chk_eq("s3_drained", bus.o_VALID, 128'd0);
    chk_eq("s3_cnt", cnt, 128'd3);

    // strides 0, 4, 512 back to back
    bus.i_VALID = 1'b1;
    bus.i_STRIDE = 10'd0;
    tick();
    chk_eq("s0_top", bus.o_BUTTERFLY_TOP, S1_TOP);
    chk_eq("s0_bot", bus.o_BUTTERFLY_BOTTOM, S1_BOT);
    bus.i_STRIDE = 10'd4;
    tick();
    chk_eq("s4_valid", bus.o_VALID, 128'd1);
    chk_eq("s4_top", bus.o_BUTTERFLY_TOP, S4_TOP);
    chk_eq("s4_bot", bus.o_BUTTERFLY_BOTTOM, S4_BOT);
    bus.i_STRIDE = 10'd512;
    tick();
    bus.i_VALID = 1'b0;
    chk_eq("s512_valid", bus.o_VALID, 128'd1);
    chk_eq("s512_top", bus.o_BUTTERFLY_TOP, S4_TOP);
    chk_eq("s512_bot", bus.o_BUTTERFLY_BOTTOM, S4_BOT);
    tick();
    chk_eq("b2b_drained", bus.o_VALID, 128'd0);
    chk_eq("b2b_cnt", cnt, 128'd6);

    // backpressure: A to OR, B to skid, C refused until skid drains
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_eq("clr_cnt", cnt, 128'd0);
    bus.i_READY = 1'b0;
    bus.i_VALID = 1'b1;
    bus.i_STRIDE = 10'd4;
    set_words(32'h100);
    tick();
    chk_eq("bp_a_top", bus.o_BUTTERFLY_TOP, S4_TOP);
    chk_eq("bp_a_ready", bus.o_READY, 128'd1);
    set_words(32'h200);
    tick();
    chk_eq("bp_full_ready", bus.o_READY, 128'd0);
    chk_eq("bp_a_hold", bus.o_BUTTERFLY_TOP, S4_TOP);
    set_words(32'h300);
    tick();
    chk_eq("bp_a_hold2", bus.o_BUTTERFLY_TOP, S4_TOP);
    chk_eq("bp_valid_hold", bus.o_VALID, 128'd1);
    bus.i_READY = 1'b1;
    tick();
    chk_eq("bp_b_top", bus.o_BUTTERFLY_TOP, B_TOP);
    chk_eq("bp_ready_back", bus.o_READY, 128'd1);
    tick();
    bus.i_VALID = 1'b0;
    chk_eq("bp_c_top", bus.o_BUTTERFLY_TOP, C_TOP);
    chk_eq("bp_c_valid", bus.o_VALID, 128'd1);
    tick();
    chk_eq("bp_drained", bus.o_VALID, 128'd0);
    chk_eq("bp_cnt", cnt, 128'd3);

    // 256-beat stream wraps the counter
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_words(32'h100);
    bus.i_STRIDE = 10'd1;
    bus.i_VALID = 1'b1;
    repeat (256) tick();
    chk_eq("stream_valid", bus.o_VALID, 128'd1);
    chk_eq("stream_cnt255", cnt, 128'd255);
    bus.i_VALID = 1'b0;
    tick();
    chk_eq("stream_wrap", cnt, 128'd0);
    chk_eq("stream_drained", bus.o_VALID, 128'd0);

    // clear coincident with a transfer
    bus.i_VALID = 1'b1;
    repeat (3) tick();
    bus.i_VALID = 1'b0;
    chk_eq("pre_clear_cnt", cnt, 128'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_eq("clear_wins", cnt, 128'd0);
    chk_eq("clear_drained", bus.o_VALID, 128'd0);

    // async reset with OR and skid both full
    bus.i_VALID = 1'b1;
    repeat (2) tick();
    bus.i_READY = 1'b0;
    tick();
    bus.i_VALID = 1'b0;
    chk_eq("prerst_ready", bus.o_READY, 128'd0);
    chk_eq("prerst_cnt", cnt, 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_valid", bus.o_VALID, 128'd0);
    chk_eq("arst_ready", bus.o_READY, 128'd1);
    chk_eq("arst_top", bus.o_BUTTERFLY_TOP, 128'd0);
    chk_eq("arst_bot", bus.o_BUTTERFLY_BOTTOM, 128'd0);
    chk_eq("arst_cnt", cnt, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_READY = 1'b1;
    repeat (2) tick();
    chk_eq("post_rst_valid", bus.o_VALID, 128'd0);
    chk_eq("post_rst_cnt", cnt, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/butterfly_xbar_in_pipe.md
Name: butterfly_xbar_in_pipe

Overview:
- Parametrised, pipelined successor of the FFT butterfly input crossbar.
- Takes two memory read beats of LANES words each and routes them into LANES butterfly top/bottom operand pairs for any power-of-two stride.
- Adds a valid/ready handshake with a 2-entry skid buffer and a beat counter.
- Sits between the dual-port coefficient/data SRAM read path and the butterfly array.

Parameters:
- DATA_W, 32, bits per complex word.
- LANES, 4, words per read beat and number of butterflies; power of two, >=2.
- STRIDE_W, 10, width of stride input.
- CNT_W, 8, width of beat counter.

Ports:
- i_CLK  input  1  clock; all logic rising-edge.
- i_RST  input  1  asynchronous, active-high reset.
- i_CLEAR  input  1  synchronous clear of beat counter.
- i_STRIDE  input  STRIDE_W  butterfly stride for this beat; sampled with data.
- i_READ_OUTPUT1  input  LANES*DATA_W  read beat 1, words w[0..LANES-1]; word j at bits [j*DATA_W +: DATA_W].
- i_READ_OUTPUT2  input  LANES*DATA_W  read beat 2, words w[LANES..2*LANES-1].
- i_VALID  input  1  input beat valid.
- o_READY  output  1  input beat accepted when i_VALID & o_READY.
- o_BUTTERFLY_TOP  output  LANES*DATA_W  top operand of butterfly b at slice b.
- o_BUTTERFLY_BOTTOM  output  LANES*DATA_W  bottom operand of butterfly b at slice b.
- o_VALID  output  1  output beat valid.
- i_READY  input  1  output beat transferred when o_VALID & i_READY.
- o_BEAT_CNT  output  CNT_W  number of output beats transferred, modulo 2^CNT_W.

Behaviour:
- Reset (i_RST high, async):
  - o_VALID=0, skid empty, o_READY=1.
  - o_BUTTERFLY_TOP/BOTTOM=0, o_BEAT_CNT=0.
  - Reset mid-operation discards all held beats immediately.
- Effective stride S:
  - i_STRIDE=0 -> S=1.
  - Otherwise S = largest power of two <= i_STRIDE, clamped to LANES.
  - Examples (LANES=4): 3 -> 2; 4 -> 4; 1000 -> 4.
- Routing, combinational on the input side, with concatenated words w[0..2*LANES-1]:
  - For butterfly b: t = (b/S)*2S + (b mod S).
  - TOP[b] = w[t]; BOTTOM[b] = w[t+S].
  - LANES=4 cases:
    - S=1: tops w0,w2,w4,w6; bottoms w1,w3,w5,w7.
    - S=2: tops w0,w1,w4,w5; bottoms w2,w3,w6,w7.
    - S=4: tops w0..w3; bottoms w4..w7.
- Routed result is registered: latency 1 cycle from input accept to o_VALID when the output is free.
- Pipeline/skid:
  - Output register (OR) plus one skid register (SK). Stride affects only routing; it is not stored separately.
  - Accept with OR empty, or OR draining this cycle (o_VALID & i_READY) and SK empty -> routed beat loads OR.
  - Accept with OR full and not draining -> routed beat loads SK.
  - OR draining with SK full -> SK moves to OR; SK empties.
  - o_READY is registered and equals !SK_full; deasserts the cycle after SK fills.
  - Any beat accepted while o_READY=1 is never lost.
  - Sustained i_VALID=i_READY=1 gives 1 beat/cycle with no bubbles.
  - Order is strictly FIFO; no beat is duplicated or dropped.
  - o_VALID holds and output data is stable while !i_READY.
- Beat counter:
  - Increments on each output transfer and wraps 2^CNT_W-1 -> 0.
  - i_CLEAR forces 0.
  - i_CLEAR together with a transfer -> 0 (clear wins).

Test Plan:
- LANES=4, words w_k = 0x100+k, i_STRIDE=1, i_READY=1, single beat -> one cycle later o_VALID=1, TOP={0x106,0x104,0x102,0x100} (b3..b0), BOTTOM={0x107,0x105,0x103,0x101}.
- Same data, i_STRIDE=2 then i_STRIDE=3 -> both give TOP={0x105,0x104,0x101,0x100}, BOTTOM={0x107,0x106,0x103,0x102}.
- i_STRIDE=0, 4, 512 back-to-back -> first beat routes as S=1; second and third route as TOP=w0..w3, BOTTOM=w4..w7. Three consecutive o_VALID cycles, in order.
- i_READY=0 while driving 3 beats A,B,C -> A held in OR, B in SK, o_READY low from the next cycle, C not accepted. Raise i_READY -> outputs A,B,C in order; o_BEAT_CNT ends at 3.
- Stream 256 beats with i_READY=1, CNT_W=8 -> o_BEAT_CNT wraps to 0. Assert i_CLEAR on a transfer cycle -> counter 0 next cycle.
- Assert i_RST asynchronously with OR and SK full -> o_VALID=0, o_READY=1, outputs 0, counter 0 immediately, no stale beat after release.
